// File: rtl/demux8_frame_rx.sv
// Collects 8 time-multiplexed channel words into one frame; frame_out/frame_valid one clock after the slot-7 beat.
// No backpressure: every din_valid beat is consumed; din_valid=0 cycles hold all state.
module demux8_frame_rx #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic [8*WIDTH-1:0]   frame_out,
    output logic                 frame_valid,
    output logic [2:0]           slot,
    output logic                 err_sync,
    output logic [7:0]           frame_cnt
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           slot_q, slot_d;
    logic [7*WIDTH-1:0]   shadow_q, shadow_d;
    logic [8*WIDTH-1:0]   frame_q, frame_d;
    logic                 fv_q, fv_d;
    logic                 err_q, err_d;
    logic [7:0]           cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= 3'd0;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            HUNT: begin
                if (din_valid && sof) begin
                    shadow_d[WIDTH-1:0] = din;
                    slot_d              = 3'd1;
                    state_d             = RECV;
                end
            end
            RECV: begin
                if (din_valid) begin
                    if (sof) begin
                        // Premature start: the partial frame is dropped and this beat becomes slot 0.
                        err_d               = 1'b1;
                        shadow_d[WIDTH-1:0] = din;
                        slot_d              = 3'd1;
                    end else if (slot_q == 3'd7) begin
                        frame_d = {din, shadow_q};
                        fv_d    = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        slot_d  = 3'd0;
                        state_d = HUNT;
                    end else begin
                        shadow_d[int'(slot_q)*WIDTH +: WIDTH] = din;
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = 3'd0;
            end
        endcase
    end

    assign frame_out   = frame_q;
    assign frame_valid = fv_q;
    assign slot        = slot_q;
    assign err_sync    = err_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_demux8_frame_rx.sv
// Directed and randomized bench for demux8_frame_rx against a queue-based frame model.
module tb_demux8_frame_rx;

    localparam int W = 3;

    logic             clk;
    logic             rst;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             sof;
    logic [8*W-1:0]   frame_out;
    logic             frame_valid;
    logic [2:0]       slot;
    logic             err_sync;
    logic [7:0]       frame_cnt;

    demux8_frame_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .err_sync    (err_sync),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words gathered so far in the current frame (empty = hunting).
    logic [W-1:0]   q[$];
    logic [8*W-1:0] exp_frame;
    logic           exp_fv;
    logic           exp_err;
    int             exp_cnt;
    int             fv_seen;
    int             err_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".frame_out"},   32'(frame_out),   32'(exp_frame));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(exp_fv));
        chk({tag, ".err_sync"},    32'(err_sync),    32'(exp_err));
        chk({tag, ".slot"},        32'(slot),        32'(q.size()));
        chk({tag, ".frame_cnt"},   32'(frame_cnt),   32'(exp_cnt));
    endtask

    task automatic model_reset();
        q.delete();
        exp_frame = '0;
        exp_fv    = 1'b0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic step(input bit v, input bit s, input logic [W-1:0] d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (s) begin
                if (q.size() > 0) exp_err = 1'b1;
                q.delete();
                q.push_back(d);
            end else if (q.size() > 0) begin
                q.push_back(d);
                if (q.size() == 8) begin
                    for (int k = 0; k < 8; k++) exp_frame[k*W +: W] = q[k];
                    exp_fv  = 1'b1;
                    exp_cnt = (exp_cnt + 1) % 256;
                    q.delete();
                end
            end
        end
        din_valid = 1'b0;
        sof       = 1'b0;
        if (frame_valid) fv_seen++;
        if (err_sync) err_seen++;
        compare_all("step");
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w [8], input int gap);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, w[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 3'(g));
        end
    endtask

    logic [W-1:0] ramp [8];
    logic [W-1:0] rnd  [8];
    int           fv0, err0, cnt0;

    initial begin
        din = '0; din_valid = 1'b0; sof = 1'b0; rst = 1'b1;
        fv_seen = 0; err_seen = 0;
        model_reset();
        for (int i = 0; i < 8; i++) ramp[i] = 3'(i);
        @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // Basic frame
        send_frame(ramp, 0);
        chk("basic.frame_out_const", 32'(frame_out), 32'h00FAC688);
        chk("basic.frame_cnt_const", 32'(frame_cnt), 32'd1);
        chk("basic.valid", 32'(frame_valid), 32'd1);
        step(1'b0, 1'b0, 3'd0);
        chk("basic.valid_one_cycle", 32'(frame_valid), 32'd0);

        // Gaps between every beat
        fv0 = fv_seen;
        send_frame(ramp, 3);
        chk("gaps.frame_out_const", 32'(frame_out), 32'h00FAC688);
        chk("gaps.single_pulse", 32'(fv_seen - fv0), 32'd1);

        // Resync on premature sof
        cnt0 = exp_cnt; err0 = err_seen;
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 3'(i + 4));
        step(1'b1, 1'b1, 3'b101);
        chk("resync.err_pulse", 32'(err_sync), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 3'b010);
        chk("resync.frame_out_const", 32'(frame_out), 32'h00492495);
        chk("resync.cnt_delta", 32'(frame_cnt), 32'((cnt0 + 1) % 256));
        chk("resync.err_count", 32'(err_seen - err0), 32'd1);

        // Hunt discard
        fv0 = fv_seen; err0 = err_seen;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'($urandom_range(7)));
        chk("hunt.slot_zero", 32'(slot), 32'd0);
        send_frame(ramp, 0);
        chk("hunt.single_pulse", 32'(fv_seen - fv0), 32'd1);
        chk("hunt.no_err", 32'(err_seen - err0), 32'd0);

        // sof without din_valid ignored
        step(1'b1, 1'b1, 3'd1);
        step(1'b0, 1'b1, 3'd2);
        chk("sof_novalid.slot", 32'(slot), 32'd1);

        // Reset mid-frame
        for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 3'(i));
        async_reset();
        chk("rst_mid.frame_out_zero", 32'(frame_out), 32'd0);
        send_frame(ramp, 0);
        chk("rst_mid.cnt_one", 32'(frame_cnt), 32'd1);

        // Counter wrap with back-to-back frames
        async_reset();
        fv0 = fv_seen;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 8; i++) rnd[i] = 3'($urandom_range(7));
            send_frame(rnd, 0);
        end
        chk("wrap.cnt_zero", 32'(frame_cnt), 32'd0);
        chk("wrap.pulses", 32'(fv_seen - fv0), 32'd256);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) async_reset();
            else step($urandom_range(3) != 0, $urandom_range(9) == 0, 3'($urandom_range(7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux8_frame_rx.md
DEMUX8_FRAME_RX -- requirements
Module: demux8_frame_rx

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the width of each channel word.
Ports:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  WIDTH  time-multiplexed channel word, one slot per accepted beat.
REQ-005 din_valid  input  1  din is valid this cycle; the block always accepts it and has no backpressure.
REQ-006 sof  input  1  start-of-frame; qualified by din_valid, marks din as slot 0.
REQ-007 frame_out  output  8*WIDTH  last complete frame; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 frame_valid  output  1  one-cycle pulse: frame_out was updated this cycle.
REQ-009 slot  output  3  index of the next slot expected; 0 in HUNT.
REQ-010 err_sync  output  1  one-cycle pulse: a frame was abandoned by a premature sof.
REQ-011 frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-012 The state machine SHALL have two states: HUNT (waiting for a frame start) and RECV (collecting slots 1..7).
REQ-013 In HUNT, a beat with din_valid=1 and sof=0 SHALL be discarded silently, with no error and no state change.
REQ-014 A beat with din_valid=1 and sof=1 in HUNT SHALL write din to shadow slot 0, set slot to 1 and enter RECV.
REQ-015 A beat with din_valid=1 and sof=0 in RECV SHALL write din to shadow[slot] and increment slot.
REQ-016 A beat accepted at slot 7 in RECV completes the frame, and the next edge SHALL do all of the following:
- load frame_out with shadow slots 0..6 plus this din as slot 7;
- assert frame_valid for exactly one cycle;
- increment frame_cnt, wrapping 255 -> 0;
- return to HUNT with slot = 0.
REQ-017 Latency SHALL be exactly one clock from the slot-7 beat to frame_valid.
REQ-018 A beat with din_valid=1 and sof=1 in RECV, at any slot 1..7, SHALL:
- discard the partial frame;
- pulse err_sync for one cycle;
- treat din as slot 0 of a new frame (slot becomes 1, state stays RECV);
- leave frame_out, frame_valid (low) and frame_cnt unchanged.
REQ-019 sof with din_valid=0 SHALL be ignored in every state.
REQ-020 Cycles with din_valid=0 SHALL hold all state; gaps of any length within a frame SHALL be tolerated.
REQ-021 frame_out SHALL change only on frame completion, atomically across all 8 channels, and hold its value otherwise.
REQ-022 Back-to-back frames SHALL be supported: a sof beat in the cycle immediately after the slot-7 beat SHALL start a new frame with no lost beat.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst=1 SHALL immediately, independent of clk, force the following: state HUNT, slot 0, frame_out 0, frame_valid 0, err_sync 0, frame_cnt 0, and all shadow slots 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first beat after reset release SHALL be handled per REQ-013/REQ-014.

Verification (WIDTH=3)
REQ-026 Basic frame: after reset, send 8 consecutive valid beats din=0..7 with sof on the first -> one cycle after the 8th beat, frame_valid=1 for one cycle, frame_out=0x FAC688 (ch0=000 ... ch7=111), frame_cnt=1, slot=0.
REQ-027 Gaps: repeat the same frame with din_valid low for 3 cycles between every beat -> identical frame_out; frame_valid pulses once; slot holds during the gaps.
REQ-028 Resync: start a frame, send slots 0..3, then a sof beat with din=101 followed by 7 beats of 010 -> err_sync pulses on the cycle after the sof beat; the completed frame has ch0=101 and ch1..7=010; frame_cnt increments by exactly 1.
REQ-029 Hunt discard: 5 valid beats without sof, then a full 8-beat frame -> the 5 beats have no effect; a single frame_valid pulse; err_sync stays 0.
REQ-030 Reset mid-frame: assert rst asynchronously after slot 4 -> all outputs are 0 immediately; a subsequent full frame completes normally with frame_cnt=1.
REQ-031 Counter wrap: 256 back-to-back frames -> frame_cnt reads 0 after the 256th frame, with 256 frame_valid pulses and no missed beats.
